// File: rtl/rv32m_div_ctrl_pkg.sv
// Shared definitions for the RV32M divide sequencer and its iterative core.
// Holds op and state encodings, boundary constants and the core iteration count.
package rv32m_div_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_FIX   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    localparam int CORE_ITER = 32;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/rv32m_div_ctrl_core.sv
// Unsigned restoring divider, one quotient bit per clock.
// Ports: start loads dividend/divisor; ok rises after CORE_ITER steps; err flags divisor==0.
module rv32m_div_ctrl_core
    import rv32m_div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        ok,
    output logic        err,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] div;
    logic [5:0]  cnt;
    logic [32:0] trial;

    // Partial remainder shifted by one bit, minus the divisor; bit 32 is the borrow.
    assign trial = {rem, quo[31]} - {1'b0, div};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem <= '0;
            quo <= '0;
            div <= '0;
            cnt <= '0;
            ok  <= 1'b0;
            err <= 1'b0;
        end else if (start) begin
            // start wins over an iteration still in progress
            rem <= '0;
            quo <= dividend;
            div <= divisor;
            cnt <= 6'(CORE_ITER);
            ok  <= 1'b0;
            err <= (divisor == 32'd0);
        end else if (cnt != 6'd0) begin
            if (!trial[32]) begin
                rem <= trial[31:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= {rem[30:0], quo[31]};
                quo <= {quo[30:0], 1'b0};
            end
            cnt <= cnt - 6'd1;
            if (cnt == 6'd1) ok <= 1'b1;
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/rv32m_div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer around the unsigned iterative core.
// Ports: in_valid/in_ready + op/rs1/rs2/in_tag in; out_valid/out_ready + out_data/out_tag out; flush, busy.
module rv32m_div_ctrl
    import rv32m_div_ctrl_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [31:0]      rs1,
    input  logic [31:0]      rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    logic [2:0]  state;
    logic [2:0]  state_n;
    logic        core_start;
    logic        core_ok;
    logic        unused_core_err;
    logic [31:0] core_quo;
    logic [31:0] core_rem;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        rem_q;
    logic        qneg_q;
    logic        rneg_q;

    logic        signed_in;
    logic        rem_in;
    logic        fast;
    logic [31:0] fast_val;
    logic        accept;
    logic [31:0] fix_val;

    assign signed_in = (op == OP_DIV) || (op == OP_REM);
    assign rem_in    = (op == OP_REM) || (op == OP_REMU);

    // Divide-by-zero and signed overflow are answered without the core.
    always_comb begin
        fast     = 1'b0;
        fast_val = '0;
        if (rs2 == 32'd0) begin
            fast     = 1'b1;
            fast_val = rem_in ? rs1 : ALL_ONES;
        end else if (signed_in && rs1 == INT_MIN && rs2 == ALL_ONES) begin
            fast     = 1'b1;
            fast_val = rem_in ? 32'd0 : INT_MIN;
        end
    end

    assign accept = (state == S_IDLE) && in_valid && !flush;

    always_comb begin
        state_n = state;
        if (flush) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:  if (in_valid) state_n = fast ? S_DONE : S_START;
                S_START: state_n = S_RUN;
                S_RUN:   if (core_ok) state_n = S_FIX;
                S_FIX:   state_n = S_DONE;
                S_DONE:  if (out_ready) state_n = S_IDLE;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        fix_val = '0;
        if (rem_q) fix_val = rneg_q ? neg32(core_rem) : core_rem;
        else       fix_val = qneg_q ? neg32(core_quo) : core_quo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            core_start <= 1'b0;
            out_data   <= '0;
            out_tag    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
        end else begin
            state      <= state_n;
            // Outputs are decoded from the next state so they are glitch-free flops.
            in_ready   <= (state_n == S_IDLE);
            busy       <= (state_n != S_IDLE);
            out_valid  <= (state_n == S_DONE);
            core_start <= (state_n == S_START);
            if (accept) begin
                out_tag <= in_tag;
                rem_q   <= rem_in;
                qneg_q  <= signed_in && (rs1[31] ^ rs2[31]);
                rneg_q  <= signed_in && rs1[31];
                // |INT_MIN| wraps to INT_MIN, which is the right unsigned magnitude.
                a_q     <= (signed_in && rs1[31]) ? neg32(rs1) : rs1;
                b_q     <= (signed_in && rs2[31]) ? neg32(rs2) : rs2;
                if (fast) out_data <= fast_val;
            end
            if (state == S_FIX && !flush) out_data <= fix_val;
        end
    end

    rv32m_div_ctrl_core u_core (
        .clk       (clk),
        .reset     (reset),
        .start     (core_start),
        .dividend  (a_q),
        .divisor   (b_q),
        .ok        (core_ok),
        .err       (unused_core_err),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

endmodule

// File: tb/tb_rv32m_div_ctrl.sv
// Self-checking bench for rv32m_div_ctrl: directed corner cases plus random ops.
// Results are compared against a plain-arithmetic RISC-V division model.
module tb_rv32m_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        busy;

    int errs   = 0;
    int checks = 0;
    int starts = 0;

    rv32m_div_ctrl #(.TAG_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.core_start === 1'b1) starts++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_fast(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        return (b == 32'd0) ||
               (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint la, lb, q, r;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        if (!o[0]) begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
        end else begin
            la = {32'd0, a};
            lb = {32'd0, b};
        end
        q = la / lb;
        r = la % lb;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    // Issue one op (caller is #1 after a rising edge) and check its result.
    task automatic do_op(input string name, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input bit hold);
        int lat;
        int s0;
        logic [31:0] exp;
        logic [31:0] d0;
        logic [4:0]  t0;
        exp = model(o, a, b);
        s0  = starts;
        out_ready = !hold;
        op = o; rs1 = a; rs2 = b; in_tag = t; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " lat"}, lat, is_fast(o, a, b) ? 0 : 35);
        check({name, " data"}, out_data, exp);
        check({name, " tag"}, {27'd0, out_tag}, {27'd0, t});
        check({name, " starts"}, starts - s0, is_fast(o, a, b) ? 0 : 1);
        check({name, " rdy_done"}, {31'd0, in_ready}, 32'd0);
        if (hold) begin
            d0 = out_data;
            t0 = out_tag;
            repeat (10) begin
                @(posedge clk); #1;
                check({name, " hold_data"}, out_data, d0);
                check({name, " hold_tag"}, {27'd0, out_tag}, {27'd0, t0});
                check({name, " hold_vld"}, {31'd0, out_valid}, 32'd1);
                check({name, " hold_rdy"}, {31'd0, in_ready}, 32'd0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({name, " rdy_idle"}, {31'd0, in_ready}, 32'd1);
        check({name, " vld_idle"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] spec_vals [5];
        logic [31:0] a, b;
        logic [1:0]  o;
        spec_vals[0] = 32'd0;
        spec_vals[1] = 32'd1;
        spec_vals[2] = 32'h8000_0000;
        spec_vals[3] = 32'hFFFF_FFFF;
        spec_vals[4] = 32'd7;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = 2'd0; rs1 = '0; rs2 = '0; in_tag = '0;
        #13;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst out_tag", {27'd0, out_tag}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        do_op("div_m7_2",  2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3,  1'b0);
        do_op("rem_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2, 5'd4,  1'b0);
        do_op("remu_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5,  1'b0);
        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd6, 1'b0);
        for (int i = 0; i < 4; i++)
            do_op("div0", 2'(i), 32'h1234, 32'd0, 5'(i + 8), 1'b0);
        do_op("div_ovf",  2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
        do_op("rem_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
        do_op("divu_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);
        do_op("bp", 2'b00, 32'd1000, 32'hFFFF_FFFD, 5'd21, 1'b1);

        // flush and a request in the same idle cycle: not accepted
        in_valid = 1'b1; flush = 1'b1; op = 2'b01; rs1 = 32'd9; rs2 = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_pri busy", {31'd0, busy}, 32'd0);
        check("flush_pri rdy", {31'd0, in_ready}, 32'd1);

        // flush in RUN at edge N+10
        op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3; in_tag = 5'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush vld", {31'd0, out_valid}, 32'd0);
        check("flush rdy", {31'd0, in_ready}, 32'd1);
        check("flush busy", {31'd0, busy}, 32'd0);
        do_op("post_flush", 2'b01, 32'd50, 32'd5, 5'd9, 1'b0);

        // async reset mid-RUN
        op = 2'b00; rs1 = 32'd77; rs2 = 32'd5; in_tag = 5'd30; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst rdy", {31'd0, in_ready}, 32'd1);
        check("arst vld", {31'd0, out_valid}, 32'd0);
        check("arst data", out_data, 32'd0);
        check("arst tag", {27'd0, out_tag}, 32'd0);
        check("arst busy", {31'd0, busy}, 32'd0);
        check("arst start", {31'd0, dut.core_start}, 32'd0);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 150; i++) begin
            a = ($urandom_range(0, 3) == 0) ? spec_vals[$urandom_range(0, 4)]
                                            : $urandom;
            b = ($urandom_range(0, 3) == 0) ? spec_vals[$urandom_range(0, 4)]
                                            : ($urandom >> $urandom_range(0, 31));
            o = 2'($urandom_range(0, 3));
            do_op("rand", o, a, b, 5'($urandom_range(0, 31)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rv32m_div_ctrl.md
Name: rv32m_div_ctrl

Overview:
- Sequencing wrapper that turns RV32M DIV/DIVU/REM/REMU requests from the execute stage into runs of the existing unsigned iterative divider core, then returns the architecturally correct result.
- Handles operand sign conversion, the core start pulse, completion detection, result sign fix-up and the RISC-V divide-by-zero and overflow cases.
- Sits between the ID/EX operand latch and the writeback mux.
- Uses a valid/ready handshake on both sides and returns a destination tag with each result.

Parameters:
- TAG_W, 5, width of the destination-register tag carried with each op.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort of any op in flight
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request (high only in IDLE)
- op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
- rs1  input  32  dividend
- rs2  input  32  divisor
- in_tag  input  TAG_W  destination register tag
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_data  output  32  quotient or remainder
- out_tag  output  TAG_W  tag of the returned result
- busy  output  1  high in every state except IDLE

Behaviour:
- Interface rule: one clock domain (clk); reset is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_tag=0, core start=0, busy=0, in_ready=1.
- States: IDLE, START, RUN, FIX, DONE. All outputs, including the core start line, are registered.
- The core start input is edge-sensitive, so it must be glitch-free.
- Accept condition: in_valid && in_ready at edge N. The block latches op, tag, sign(rs1), sign(rs2) and the quotient sign (sA^sB, signed ops only).
- Fast path 1, rs2==0: quotient=0xFFFFFFFF, remainder=rs1. The state goes IDLE->DONE at edge N and the core is not started.
- Fast path 2, DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient=0x80000000, remainder=0. IDLE->DONE at edge N.
- Normal path: IDLE->START at edge N. The core is loaded with |rs1| and |rs2| for signed ops and with raw operands for unsigned ops. The absolute value of 0x80000000 stays 0x80000000 and is correct as an unsigned value.
- START: core start=1 for exactly one cycle. Edge N+1 -> RUN.
- RUN: wait for core ok=1. The core iterates on edges N+2..N+33, ok rises after N+33, and RUN->FIX at edge N+34.
- ok is ignored in the START cycle.
- FIX: the quotient is negated if the quotient sign=1. The remainder is negated if sign(rs1)=1 and the op is signed. The selected value is registered into out_data. FIX->DONE at edge N+35.
- Normal latency: out_valid high after edge N+35. Fast-path latency: out_valid high after edge N.
- DONE: out_valid=1, and out_data/out_tag hold stable until out_ready. When out_valid && out_ready, DONE->IDLE on that edge. No new request is accepted in the same cycle (no back-to-back overlap).
- flush=1: next edge forces IDLE and out_valid=0 from any state, and a result in DONE is dropped. The core may still be running; the next START reloads it because the core's start has priority over iteration.
- flush has priority over accept: with in_valid and flush in the same IDLE cycle, the request is not accepted.
- Async reset mid-op: immediate return to the reset values. The same reset line also drives the core.
- Core err output: unused, because divide-by-zero is decided by the fast path before the core is started.
- Signed remainder sign follows the dividend, and |rem| < |divisor| always holds (RISC-V truncating division).

Decomposition:
- Shared header rv32m_div_defs.vh holds:
  - op encodings DIV/DIVU/REM/REMU
  - state encodings
  - constants INT_MIN=0x80000000 and ALL_ONES=0xFFFFFFFF
  - CORE_ITER=32
- One sub-module: the existing unsigned divider core, instantiated as u_core.
- Sign conversion and fix-up stay inline.

Test Plan:
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> out_data=0xFFFFFFFD (-3); out_valid rises after edge N+35; tag echoed.
- REM -7,2 -> 0xFFFFFFFF (-1). REMU 0xFFFFFFF9,2 -> 1. DIVU 100,7 -> 14.
- Any op with rs2=0 and rs1=0x1234: DIV/DIVU -> 0xFFFFFFFF, REM/REMU -> 0x1234. out_valid is high after edge N and u_core start never pulses.
- DIV 0x80000000 by 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0. DIVU of the same operands -> 0x00000000 via the normal 35-edge path.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_data/out_tag stable, in_ready=0. Raise out_ready -> IDLE next edge, in_ready=1.
- Abort: flush in RUN at edge N+10 -> IDLE and out_valid=0. A new DIVU 50,5 accepted next -> 10. A separate run drops reset low mid-RUN -> all outputs return to their reset values immediately.
